bcd_serial_addsub_ctrl: RTL and testbench

//  Digit-serial controller for N-digit packed-BCD add/subtract. It shares one BCD digit adder

---
 rtl/bcd_serial_addsub_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bcd_serial_addsub_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial packed-BCD add/subtract controller.
// One shared BCD digit adder walks the operands least-significant digit first,
// one digit per clock. Subtraction is a + nines(b) + 1 (ten's complement).
module bcd_serial_addsub_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);

    localparam int unsigned W        = 4 * DIGITS;
    localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             carry, carry_next;
    logic             sub_q, sub_next;
    logic [W-1:0]     a_q, a_next;
    logic [W-1:0]     b_q, b_next;
    logic [W-1:0]     result_next;
    logic             busy_next, done_next, cout_next, neg_next, err_next;

    logic [3:0]       a_dig, b_dig, dig;
    logic [4:0]       dsum;
    logic             dcarry;

    // True when any 4-bit digit of v is not a valid BCD digit.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Per-digit nines complement (9 - d).
    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(4'd9 - v[4*i +: 4]);
        end
        return r;
    endfunction

    // Shared BCD digit adder on the current digit position.
    always_comb begin
        a_dig  = a_q[{idx, 2'b00} +: 4];
        b_dig  = b_q[{idx, 2'b00} +: 4];
        dsum   = 5'(a_dig) + 5'(b_dig) + 5'(carry);
        dcarry = (dsum > 5'd9);
        dig    = dcarry ? 4'(dsum + 5'd6) : dsum[3:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        carry_next  = carry;
        sub_next    = sub_q;
        a_next      = a_q;
        b_next      = b_q;
        result_next = result;
        cout_next   = cout;
        neg_next    = neg;
        err_next    = err;
        busy_next   = 1'b0;
        done_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_next      = a;
                    b_next      = sub ? nines(b) : b;
                    sub_next    = sub;
                    carry_next  = sub;
                    idx_next    = '0;
                    result_next = '0;
                    cout_next   = 1'b0;
                    neg_next    = 1'b0;
                    if (has_bad_digit(a) || has_bad_digit(b)) begin
                        err_next   = 1'b1;
                        done_next  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        err_next   = 1'b0;
                        busy_next  = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                result_next[{idx, 2'b00} +: 4] = dig;
                carry_next = dcarry;
                idx_next   = idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    cout_next  = dcarry;
                    neg_next   = sub_q & ~dcarry;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    busy_next  = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cout   <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            carry  <= carry_next;
            sub_q  <= sub_next;
            a_q    <= a_next;
            b_q    <= b_next;
            result <= result_next;
            busy   <= busy_next;
            done   <= done_next;
            cout   <= cout_next;
            neg    <= neg_next;
            err    <= err_next;
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Self-checking bench for bcd_serial_addsub_ctrl (DIGITS=4): fixed vectors,
// randomized operations against an integer-arithmetic model, and corner sequences.
module tb_bcd_serial_addsub_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;
    localparam int          MOD    = 10000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         neg;
    logic         err;

    int total = 0;
    int passed = 0;

    bcd_serial_addsub_ctrl #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] result;
        logic         cout;
        logic         neg;
        logic         err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Plain-arithmetic reference: decimal values, modulo 10^DIGITS.
    function automatic bit bcd_valid(input logic [W-1:0] v);
        logic [W-1:0] t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[3:0] > 4'd9) return 1'b0;
            t = t >> 4;
        end
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] r, output logic c, output logic n, output logic e);
        int s;
        if (!bcd_valid(ma) || !bcd_valid(mb)) begin
            r = '0; c = 1'b0; n = 1'b0; e = 1'b1;
        end else begin
            if (ms) s = bcd2int(ma) - bcd2int(mb) + MOD;
            else    s = bcd2int(ma) + bcd2int(mb);
            r = int2bcd(s % MOD);
            c = (s >= MOD);
            n = ms & ~c;
            e = 1'b0;
        end
    endtask

    // Issue one operation, scramble inputs after capture, wait (bounded) for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                          input string tag,
                          output logic [W-1:0] r, output logic c, output logic n,
                          output logic e, output int lat, output int bcnt);
        int  k;
        bit  seen;
        @(negedge clk);
        a = ta; b = tb_b; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = ~ts;
        k = 0; bcnt = 0; lat = -1; seen = 1'b0;
        r = '0; c = 1'b0; n = 1'b0; e = 1'b0;
        while (!seen && k < 20) begin
            if (busy) begin
                bcnt++;
                if (k >= 1) chk({tag, " partial_upper_zero"}, 32'(result >> (4 * k)), 32'd0);
            end
            if (done) begin
                seen = 1'b1; lat = k;
                r = result; c = cout; n = neg; e = err;
            end else begin
                k++;
                @(negedge clk);
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
    endtask

    vec_t vecs[12];
    logic [W-1:0] r_act, r_exp;
    logic c_act, n_act, e_act, c_exp, n_exp, e_exp;
    int lat, bcnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h9999, 16'h9999, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'h1234, 16'h00F0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy",   32'(busy),   32'd0);
        chk("reset done",   32'(done),   32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset flags",  32'({cout, neg, err}), 32'd0);

        // Fixed vectors.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, $sformatf("vec%0d", i),
                   r_act, c_act, n_act, e_act, lat, bcnt);
            chk($sformatf("vec%0d result", i), 32'(r_act), 32'(vecs[i].result));
            chk($sformatf("vec%0d cout", i),   32'(c_act), 32'(vecs[i].cout));
            chk($sformatf("vec%0d neg", i),    32'(n_act), 32'(vecs[i].neg));
            chk($sformatf("vec%0d err", i),    32'(e_act), 32'(vecs[i].err));
            chk($sformatf("vec%0d latency", i), 32'(lat),  vecs[i].err ? 32'd0 : 32'(DIGITS));
            chk($sformatf("vec%0d busy_cycles", i), 32'(bcnt), vecs[i].err ? 32'd0 : 32'(DIGITS));
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
                else
                    rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            end
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, r_exp, c_exp, n_exp, e_exp);
            run_op(ra, rb, rs, $sformatf("rnd%0d", i), r_act, c_act, n_act, e_act, lat, bcnt);
            chk($sformatf("rnd%0d a=%h b=%h sub=%0d outputs", i, ra, rb, rs),
                32'({r_act, c_act, n_act, e_act}), 32'({r_exp, c_exp, n_exp, e_exp}));
            chk($sformatf("rnd%0d latency", i), 32'(lat), e_exp ? 32'd0 : 32'(DIGITS));
        end

        // Start pulses during RUN and during DONE are ignored.
        begin
            int k;
            @(negedge clk);
            a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = 0;
            while (!done && k < 20) begin
                k++;
                @(negedge clk);
            end
            chk("ignore_run done_seen", 32'(done), 32'd1);
            chk("ignore_run result", 32'(result), 32'h6912);
            a = 16'h0000; b = 16'h0000; sub = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("ignore_done busy", 32'(busy), 32'd0);
            chk("ignore_done done", 32'(done), 32'd0);
            chk("ignore_done result", 32'(result), 32'h6912);
        end

        // Reset on the second RUN cycle: immediate clear, no done pulse afterwards.
        begin
            int dcnt, bc;
            @(negedge clk);
            a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("pre_rst result digit0", 32'(result), 32'h0002);
            rst = 1'b1;
            #1;
            chk("mid_rst busy",   32'(busy),   32'd0);
            chk("mid_rst result", 32'(result), 32'd0);
            chk("mid_rst flags",  32'({done, cout, neg, err}), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            dcnt = 0; bc = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done) dcnt++;
                if (busy) bc++;
            end
            chk("post_rst done_pulses", 32'(dcnt), 32'd0);
            chk("post_rst busy_cycles", 32'(bc), 32'd0);
            chk("post_rst result", 32'(result), 32'd0);
        end

        // Start held high: a new operation every DIGITS+2 cycles.
        begin
            int cyc, nd;
            int dcyc[3];
            @(negedge clk);
            a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
            cyc = 0; nd = 0;
            while (nd < 3 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    dcyc[nd] = cyc;
                    nd++;
                end
            end
            start = 1'b0;
            chk("b2b done_count", 32'(nd), 32'd3);
            if (nd == 3) begin
                chk("b2b period1", 32'(dcyc[1] - dcyc[0]), 32'(DIGITS + 2));
                chk("b2b period2", 32'(dcyc[2] - dcyc[1]), 32'(DIGITS + 2));
            end
            chk("b2b result", 32'(result), 32'h0002);
            repeat (DIGITS + 3) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
